// File: rtl/image_stream_processor_if.sv
// Read and write memory buses of image_stream_processor.
// master = processor side, slave = frame/result RAM side.
interface image_stream_processor_if #(
  parameter int WidthAddressSize  = 6,
  parameter int HeightAddressSize = 6,
  parameter int Resolution        = 8,
  parameter int Channels          = 3
);
  localparam int P = Resolution * Channels;

  logic [HeightAddressSize-1:0] readLine;
  logic [WidthAddressSize-1:0]  readColumn;
  logic [P-1:0]                 pixelA;
  logic [P-1:0]                 pixelB;
  logic [P-1:0]                 outPixel;
  logic [HeightAddressSize-1:0] writeLine;
  logic [WidthAddressSize-1:0]  writeColumn;
  logic                         writePixel;

  modport master (
    output readLine,
    output readColumn,
    input  pixelA,
    input  pixelB,
    output outPixel,
    output writeLine,
    output writeColumn,
    output writePixel
  );

  modport slave (
    input  readLine,
    input  readColumn,
    output pixelA,
    output pixelB,
    input  outPixel,
    input  writeLine,
    input  writeColumn,
    input  writePixel
  );
endinterface

// File: rtl/image_stream_processor.sv
// Raster-scan two-source pixel processor with mirror/translate addressing.
// Define IMAGE_STREAM_SATURATE_EN to clamp add/subtract instead of wrapping.
module image_stream_processor #(
  parameter int WidthAddressSize  = 6,
  parameter int HeightAddressSize = 6,
  parameter int Resolution        = 8,
  parameter int Channels          = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic                         start,
  input  logic                         invertX,
  input  logic                         invertY,
  input  logic [WidthAddressSize-1:0]  translateX,
  input  logic [HeightAddressSize-1:0] translateY,
  input  logic [2:0]                   opcode,
  input  logic [Resolution-1:0]        alpha,
  image_stream_processor_if.master     bus,
  output logic                         busy,
  output logic                         done
);
  localparam int P  = Resolution * Channels;
  localparam int CW = WidthAddressSize + HeightAddressSize;
  localparam int MW = 2 * Resolution + 1;

  typedef enum logic [1:0] {Idle, Scan, Drain} state_t;

  state_t state, stateNext;
  logic [CW-1:0] scanIdx;
  logic [HeightAddressSize-1:0] line, line1, wLineQ;
  logic [WidthAddressSize-1:0] col, col1, wColQ;
  logic drainCnt, lastPix, doneQ, doneNext;
  logic valid1, writeQ;

  logic [2:0] opQ;
  logic [Resolution-1:0] alphaQ;
  logic invXQ, invYQ;
  logic [WidthAddressSize-1:0] txQ;
  logic [HeightAddressSize-1:0] tyQ;

  logic ceQ;
  logic [P-1:0] holdA, holdB, srcA, srcB;
  logic [P-1:0] result, outQ;

  assign line = scanIdx[CW-1:WidthAddressSize];
  assign col = scanIdx[WidthAddressSize-1:0];
  assign lastPix = (&line) && (&col);

  function automatic logic [Resolution-1:0] chanOp(
    input logic [2:0]            op,
    input logic [Resolution-1:0] a,
    input logic [Resolution-1:0] b,
    input logic [Resolution-1:0] al
  );
    logic [Resolution:0] sum, diff;
    logic [MW-1:0] mix;
    logic [Resolution-1:0] r;
    logic [Resolution-1:0] inv;
    sum = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    inv = ~al;
    mix = MW'(a) * MW'(al) + MW'(b) * MW'(inv)
        + (MW'(1) << (Resolution - 1));
    r = '0;
    unique case (op)
      3'b000: r = a;
      3'b001: r = b;
`ifdef IMAGE_STREAM_SATURATE_EN
      3'b010: r = sum[Resolution] ? '1 : sum[Resolution-1:0];
      3'b011: r = diff[Resolution] ? '0 : diff[Resolution-1:0];
`else
      3'b010: r = Resolution'(sum);
      3'b011: r = Resolution'(diff);
`endif
      3'b100: r = diff[Resolution] ? (b - a) : (a - b);
      3'b101: r = (a > b) ? a : b;
      3'b110: r = (a < b) ? a : b;
      3'b111: r = Resolution'(mix >> Resolution);
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    stateNext = state;
    doneNext = 1'b0;
    unique case (state)
      Idle: if (start) stateNext = Scan;
      Scan: if (lastPix) stateNext = Drain;
      Drain: begin
        if (drainCnt) begin
          stateNext = Idle;
          doneNext = 1'b1;
        end
      end
      default: stateNext = Idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= Idle;
      scanIdx <= '0;
      drainCnt <= 1'b0;
      doneQ <= 1'b0;
    end else if (ce) begin
      state <= stateNext;
      doneQ <= doneNext;
      unique case (state)
        Idle: if (start) scanIdx <= '0;
        Scan: begin
          drainCnt <= 1'b0;
          if (!lastPix) scanIdx <= scanIdx + CW'(1);
        end
        Drain: drainCnt <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opQ <= '0;
      alphaQ <= '0;
      invXQ <= 1'b0;
      invYQ <= 1'b0;
      txQ <= '0;
      tyQ <= '0;
    end else if (ce && state == Idle && start) begin
      opQ <= opcode;
      alphaQ <= alpha;
      invXQ <= invertX;
      invYQ <= invertY;
      txQ <= translateX;
      tyQ <= translateY;
    end
  end

  // Mirror is a bitwise invert because the frame size is a power of two.
  assign bus.readColumn = (invXQ ? ~col : col) + txQ;
  assign bus.readLine = (invYQ ? ~line : line) + tyQ;

  // RAM keeps clocking during a stall, so keep the word fetched
  // for the stalled address until stage 2 consumes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ceQ <= 1'b0;
      holdA <= '0;
      holdB <= '0;
    end else begin
      ceQ <= ce;
      if (!ce && ceQ) begin
        holdA <= bus.pixelA;
        holdB <= bus.pixelB;
      end
    end
  end

  assign srcA = ceQ ? bus.pixelA : holdA;
  assign srcB = ceQ ? bus.pixelB : holdB;

  always_comb begin
    result = '0;
    for (int c = 0; c < Channels; c++) begin
      result[c*Resolution +: Resolution] = chanOp(
        opQ,
        srcA[c*Resolution +: Resolution],
        srcB[c*Resolution +: Resolution],
        alphaQ);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1 <= 1'b0;
      line1 <= '0;
      col1 <= '0;
      writeQ <= 1'b0;
      outQ <= '0;
      wLineQ <= '0;
      wColQ <= '0;
    end else if (ce) begin
      valid1 <= (state == Scan);
      line1 <= line;
      col1 <= col;
      writeQ <= valid1;
      if (valid1) begin
        outQ <= result;
        wLineQ <= line1;
        wColQ <= col1;
      end
    end
  end

  assign bus.outPixel = outQ;
  assign bus.writeLine = wLineQ;
  assign bus.writeColumn = wColQ;
  assign bus.writePixel = writeQ & ce;
  assign done = doneQ & ce;
  assign busy = (state != Idle);
endmodule

// File: tb/tb_image_stream_processor.sv
// Self-checking bench for image_stream_processor on a 4x4 frame.
// Reference model computes expected writes from frame rules.
module tb_image_stream_processor;
  localparam int WA = 2;
  localparam int HA = 2;
  localparam int R = 8;
  localparam int CH = 3;
  localparam int W = 1 << WA;
  localparam int H = 1 << HA;
  localparam int N = W * H;
  localparam int P = R * CH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b1;
  logic start = 1'b0;
  logic invertX = 1'b0;
  logic invertY = 1'b0;
  logic [WA-1:0] translateX = '0;
  logic [HA-1:0] translateY = '0;
  logic [2:0] opcode = '0;
  logic [R-1:0] alpha = '0;
  logic busy, done;

  image_stream_processor_if #(
    .WidthAddressSize(WA), .HeightAddressSize(HA),
    .Resolution(R), .Channels(CH)
  ) bus ();

  image_stream_processor #(
    .WidthAddressSize(WA), .HeightAddressSize(HA),
    .Resolution(R), .Channels(CH)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start),
    .invertX(invertX), .invertY(invertY),
    .translateX(translateX), .translateY(translateY),
    .opcode(opcode), .alpha(alpha), .bus(bus),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [P-1:0] memA [N];
  logic [P-1:0] memB [N];

  always @(posedge clk) begin
    bus.pixelA <= memA[{bus.readLine, bus.readColumn}];
    bus.pixelB <= memB[{bus.readLine, bus.readColumn}];
  end

  typedef struct {
    logic [P-1:0] data;
    int line;
    int col;
  } wr_t;

  wr_t expQ[$];
  wr_t e;
  int nChecks = 0;
  int nFails = 0;
  logic [P-1:0] firstOut;
  bit gotFirst;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int chanRef(int op, int a, int b, int al);
    int s;
    int m;
    m = (1 << R) - 1;
    case (op)
      0: s = a;
      1: s = b;
`ifdef IMAGE_STREAM_SATURATE_EN
      2: s = (a + b > m) ? m : a + b;
      3: s = (a < b) ? 0 : a - b;
`else
      2: s = (a + b) % (m + 1);
      3: s = (a - b + m + 1) % (m + 1);
`endif
      4: s = (a > b) ? a - b : b - a;
      5: s = (a > b) ? a : b;
      6: s = (a < b) ? a : b;
      default: s = (a * al + b * (m - al) + (1 << (R - 1))) >> R;
    endcase
    return s;
  endfunction

  function automatic logic [P-1:0] pixRef(int op, logic [P-1:0] a,
                                          logic [P-1:0] b, int al);
    logic [P-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++)
      r[c*R +: R] = R'(chanRef(op, int'(a[c*R +: R]),
                               int'(b[c*R +: R]), al));
    return r;
  endfunction

  task automatic buildExpect(int op, int al, bit ix, bit iy,
                             int tx, int ty);
    wr_t w;
    int sl, sc;
    expQ.delete();
    for (int k = 0; k < N; k++) begin
      w.line = k / W;
      w.col = k % W;
      sc = ((ix ? W - 1 - w.col : w.col) + tx) % W;
      sl = ((iy ? H - 1 - w.line : w.line) + ty) % H;
      w.data = pixRef(op, memA[sl*W+sc], memB[sl*W+sc], al);
      expQ.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    if (bus.writePixel) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL extraWrite: got write at %0d,%0d, expected none",
                 bus.writeLine, bus.writeColumn);
      end else begin
        e = expQ.pop_front();
        chk("writeData", bus.outPixel, e.data);
        chk("writeLine", bus.writeLine, e.line);
        chk("writeColumn", bus.writeColumn, e.col);
        if (!gotFirst) begin
          firstOut = bus.outPixel;
          gotFirst = 1;
        end
      end
    end
    if (!ce) chk("ceLowStrobes", {bus.writePixel, done}, 0);
  end

  task automatic scramble();
    opcode = 3'($urandom);
    alpha = R'($urandom);
    invertX = 1'($urandom);
    invertY = 1'($urandom);
    translateX = WA'($urandom);
    translateY = HA'($urandom);
  endtask

  task automatic runFrame(input logic [2:0] op, input logic [R-1:0] al,
                          input bit ix, input bit iy,
                          input logic [WA-1:0] tx, input logic [HA-1:0] ty,
                          input int stallAt, input int startAt,
                          input int rstAt, input bit addrChk);
    int cyc;
    int stall;
    bit seen;
    buildExpect(int'(op), int'(al), ix, iy, int'(tx), int'(ty));
    gotFirst = 0;
    @(negedge clk);
    opcode = op;
    alpha = al;
    invertX = ix;
    invertY = iy;
    translateX = tx;
    translateY = ty;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    scramble();
    cyc = 0;
    stall = (stallAt >= 0) ? 3 : 0;
    seen = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
      seen = done;
      if (!seen) chk("busyHigh", busy, 1);
      if (addrChk && cyc == 1) chk("readColumnCol0", bus.readColumn, 0);
      if (addrChk && cyc == 2) chk("readColumnCol1", bus.readColumn, 3);
      if (cyc == startAt) begin
        start = 1;
        scramble();
      end
      if (cyc == startAt + 1) start = 0;
      if (cyc == stallAt) ce = 0;
      if (cyc == stallAt + 3) ce = 1;
      if (cyc == rstAt) begin
        rst = 1;
        #1;
        chk("rstStrobes", {bus.writePixel, busy, done}, 0);
        chk("rstOutputs", {bus.readLine, bus.readColumn, bus.writeLine,
                           bus.writeColumn, bus.outPixel}, 0);
        expQ.delete();
        @(negedge clk);
        rst = 0;
        return;
      end
    end
    chk("doneSeen", seen, 1);
    chk("doneCycle", cyc, N + 3 + stall);
    chk("busyAtDone", busy, 0);
    chk("pendingWrites", expQ.size(), 0);
    @(negedge clk);
    #1;
    chk("donePulse", done, 0);
    chk("idleBusy", busy, 0);
  endtask

  task automatic fillMem(input int kind);
    for (int i = 0; i < N; i++) begin
      memA[i] = P'($urandom);
      memB[i] = P'($urandom);
      if (kind == 1) memA[i] = {CH{R'(i)}};
    end
  endtask

  task automatic fillConst(input logic [R-1:0] a, input logic [R-1:0] b);
    for (int i = 0; i < N; i++) begin
      memA[i] = {CH{a}};
      memB[i] = {CH{b}};
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [R-1:0] addExp, subExp;
`ifdef IMAGE_STREAM_SATURATE_EN
    addExp = 8'd255;
    subExp = 8'd0;
`else
    addExp = 8'd44;
    subExp = 8'd246;
`endif
    fillMem(0);
    repeat (2) @(negedge clk);
    chk("resetStrobes", {bus.writePixel, busy, done}, 0);
    chk("resetOutputs", {bus.readLine, bus.readColumn, bus.writeLine,
                         bus.writeColumn, bus.outPixel}, 0);
    rst = 0;

    fillMem(1);
    runFrame(3'd0, 8'd0, 0, 0, 2'd0, 2'd0, -1, -1, -1, 0);
    fillMem(0);
    runFrame(3'd0, 8'd0, 1, 0, 2'd1, 2'd0, -1, -1, -1, 1);

    fillConst(8'd200, 8'd100);
    runFrame(3'd2, 8'd0, 0, 0, 2'd0, 2'd0, -1, -1, -1, 0);
    chk("addLiteral", firstOut, {CH{addExp}});
    fillConst(8'd10, 8'd20);
    runFrame(3'd3, 8'd0, 0, 0, 2'd0, 2'd0, -1, -1, -1, 0);
    chk("subLiteral", firstOut, {CH{subExp}});
    fillConst(8'd200, 8'd100);
    runFrame(3'd7, 8'd128, 0, 0, 2'd0, 2'd0, -1, -1, -1, 0);
    chk("blendLiteral128", firstOut, {CH{8'd150}});
    fillConst(8'd255, 8'd0);
    runFrame(3'd7, 8'd255, 0, 0, 2'd0, 2'd0, -1, -1, -1, 0);
    chk("blendLiteral255", firstOut, {CH{8'd254}});

    for (int f = 0; f < 6; f++) begin
      fillMem(0);
      runFrame(3'($urandom), R'($urandom), 1'($urandom), 1'($urandom),
               WA'($urandom), HA'($urandom),
               (f == 1) ? 8 : -1,
               (f == 1) ? 5 : ((f == 2) ? N + 2 : -1),
               -1, 0);
    end

    fillMem(1);
    runFrame(3'd0, 8'd0, 0, 0, 2'd0, 2'd0, -1, -1, 6, 0);
    repeat (3) @(negedge clk);
    chk("postResetIdle", {bus.writePixel, busy, done}, 0);
    fillMem(0);
    runFrame(3'd4, 8'd0, 0, 1, 2'd2, 2'd3, -1, -1, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end
endmodule
